// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared ROB sizing constants and pointer types for the rename/ROB slice.
package rob_alloc_ctrl_pkg;

    localparam int unsigned ISSUE_WIDTH_MAX = 2;
    localparam int unsigned ROB_MAX_RETIRE  = 2;
    localparam int unsigned ROB_SIZE        = 32;
    localparam int unsigned ROB_SIZE_CLOG   = 5;

    typedef logic [ROB_SIZE_CLOG-1:0] rob_ptr_t;
    typedef logic [ROB_SIZE_CLOG:0]   rob_cnt_t;

    // Forward distance from 'from' to 'to' around the ring; relies on power-of-two size.
    function automatic rob_ptr_t rob_dist(input rob_ptr_t to, input rob_ptr_t from);
        return to - from;
    endfunction

endpackage

// File: rtl/rob_thermo_cnt.sv
// Population count of a valid vector plus a flag telling whether it is a
// legal thermometer code (all set bits packed from bit 0 upwards).
module rob_thermo_cnt #(
    parameter int unsigned W  = 2,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o,
    output logic          thermo_o
);

    always_comb begin
        cnt_o    = '0;
        thermo_o = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
        for (int unsigned i = 1; i < W; i++) begin
            if (vec_i[i] && !vec_i[i-1]) begin
                thermo_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation/pointer controller: hands out ROB ids to rename, reclaims
// them on in-order retirement and rolls the tail back on mispredict.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [ISSUE_WIDTH_MAX-1:0]                    instr_val_id,
    input  logic [ROB_MAX_RETIRE-1:0]                     val_ret,
    input  logic                                          branch_clear_id,
    input  logic [ROB_SIZE_CLOG-1:0]                      mispredict_tag_id,
    output logic [ROB_SIZE_CLOG-1:0]                      rob_is_ptr,
    output logic [ROB_SIZE_CLOG-1:0]                      rob_ret_ptr,
    output logic [ISSUE_WIDTH_MAX-1:0][ROB_SIZE_CLOG-1:0] alloc_robid,
    output logic [ISSUE_WIDTH_MAX-1:0]                    alloc_fire,
    output logic                                          rob_full,
    output logic                                          rob_empty,
    output logic [ROB_SIZE_CLOG:0]                        rob_count,
    output logic [ROB_SIZE-1:0]                           rob_ety_val,
    output logic                                          ret_err,
    output logic                                          flush_err
);

    localparam int unsigned AW = $clog2(ISSUE_WIDTH_MAX + 1);
    localparam int unsigned RW = $clog2(ROB_MAX_RETIRE + 1);

    rob_ptr_t            tail_q, tail_d;
    rob_ptr_t            head_q, head_d;
    rob_cnt_t            count_q, count_d;
    logic [ROB_SIZE-1:0] ety_q, ety_d;
    logic                ret_err_q, ret_err_d;
    logic                flush_err_q, flush_err_d;

    logic [AW-1:0] alloc_n;
    logic          alloc_thermo_unused;
    logic [RW-1:0] ret_cnt;
    logic [RW-1:0] ret_n;
    logic          ret_thermo;
    logic          ret_ok;
    logic          alloc_en;
    logic          flush_ok;
    rob_ptr_t      grant_ptr;
    rob_cnt_t      flush_span;

    assign rob_is_ptr  = tail_q;
    assign rob_ret_ptr = head_q;
    assign rob_count   = count_q;
    assign rob_ety_val = ety_q;
    assign ret_err     = ret_err_q;
    assign flush_err   = flush_err_q;

    // Decoded from the count register alone so no input reaches rob_full.
    assign rob_full  = (rob_cnt_t'(ROB_SIZE) - count_q) < rob_cnt_t'(ISSUE_WIDTH_MAX);
    assign rob_empty = (count_q == '0);

    assign alloc_en = !rob_full && !branch_clear_id;
    assign ret_ok   = ret_thermo && (rob_cnt_t'(ret_cnt) <= count_q);
    assign ret_n    = ret_ok ? ret_cnt : '0;
    assign flush_ok = branch_clear_id && ety_q[mispredict_tag_id];

    always_comb begin
        grant_ptr   = tail_q;
        alloc_fire  = '0;
        alloc_robid = {ISSUE_WIDTH_MAX{tail_q}};
        for (int unsigned i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            if (alloc_en && instr_val_id[i]) begin
                alloc_fire[i]  = 1'b1;
                alloc_robid[i] = grant_ptr;
                grant_ptr      = grant_ptr + rob_ptr_t'(1);
            end
        end
    end

    rob_thermo_cnt #(.W(ROB_MAX_RETIRE)) u_ret_cnt (
        .vec_i    (val_ret),
        .cnt_o    (ret_cnt),
        .thermo_o (ret_thermo)
    );

    rob_thermo_cnt #(.W(ISSUE_WIDTH_MAX)) u_alloc_cnt (
        .vec_i    (alloc_fire),
        .cnt_o    (alloc_n),
        .thermo_o (alloc_thermo_unused)
    );

    always_comb begin
        rob_ptr_t idx;
        rob_ptr_t off;
        idx = '0;
        off = '0;

        // tail == tag only when the ROB is full, so every other entry is younger.
        if (tail_q == mispredict_tag_id) begin
            flush_span = rob_cnt_t'(ROB_SIZE);
        end else begin
            flush_span = rob_cnt_t'(rob_dist(tail_q, mispredict_tag_id));
        end

        ety_d = ety_q;
        for (int unsigned k = 0; k < ROB_MAX_RETIRE; k++) begin
            idx = head_q + rob_ptr_t'(k);
            if (ret_ok && val_ret[k]) begin
                ety_d[idx] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            if (alloc_fire[i]) begin
                ety_d[alloc_robid[i]] = 1'b1;
            end
        end
        for (int unsigned j = 0; j < ROB_SIZE; j++) begin
            off = rob_dist(rob_ptr_t'(j), mispredict_tag_id);
            if (flush_ok && (off != '0) && (rob_cnt_t'(off) < flush_span)) begin
                ety_d[j] = 1'b0;
            end
        end

        if (flush_ok) begin
            tail_d  = mispredict_tag_id + rob_ptr_t'(1);
            count_d = rob_cnt_t'(rob_dist(mispredict_tag_id, head_q)) + rob_cnt_t'(1)
                      - rob_cnt_t'(ret_n);
        end else begin
            tail_d  = tail_q + rob_ptr_t'(alloc_n);
            count_d = count_q + rob_cnt_t'(alloc_n) - rob_cnt_t'(ret_n);
        end
        head_d = head_q + rob_ptr_t'(ret_n);

        ret_err_d   = ret_err_q | ~ret_ok;
        flush_err_d = flush_err_q | (branch_clear_id & ~ety_q[mispredict_tag_id]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tail_q      <= '0;
            head_q      <= '0;
            count_q     <= '0;
            ety_q       <= '0;
            ret_err_q   <= 1'b0;
            flush_err_q <= 1'b0;
        end else begin
            tail_q      <= tail_d;
            head_q      <= head_d;
            count_q     <= count_d;
            ety_q       <= ety_d;
            ret_err_q   <= ret_err_d;
            flush_err_q <= flush_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (($countones(ety_q) == int'(count_q)) && (count_q <= rob_cnt_t'(ROB_SIZE)));
        end
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl with a behavioural ROB model feeding a
// scoreboard of expected post-edge state.
module tb_rob_alloc_ctrl;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     instr_val_id;
    logic [1:0]     val_ret;
    logic           branch_clear_id;
    logic [4:0]     mispredict_tag_id;
    logic [4:0]     rob_is_ptr;
    logic [4:0]     rob_ret_ptr;
    logic [1:0][4:0] alloc_robid;
    logic [1:0]     alloc_fire;
    logic           rob_full;
    logic           rob_empty;
    logic [5:0]     rob_count;
    logic [31:0]    rob_ety_val;
    logic           ret_err;
    logic           flush_err;

    always #5 clk = ~clk;

    rob_alloc_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .instr_val_id      (instr_val_id),
        .val_ret           (val_ret),
        .branch_clear_id   (branch_clear_id),
        .mispredict_tag_id (mispredict_tag_id),
        .rob_is_ptr        (rob_is_ptr),
        .rob_ret_ptr       (rob_ret_ptr),
        .alloc_robid       (alloc_robid),
        .alloc_fire        (alloc_fire),
        .rob_full          (rob_full),
        .rob_empty         (rob_empty),
        .rob_count         (rob_count),
        .rob_ety_val       (rob_ety_val),
        .ret_err           (ret_err),
        .flush_err         (flush_err)
    );

    typedef struct packed {
        logic [4:0]  tail;
        logic [4:0]  head;
        logic [5:0]  count;
        logic [31:0] ety;
        logic        full;
        logic        empty;
        logic        rerr;
        logic        ferr;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    int          m_tail, m_head, m_count;
    logic [31:0] m_ety;
    logic        m_rerr, m_ferr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tail  = 0;
        m_head  = 0;
        m_count = 0;
        m_ety   = '0;
        m_rerr  = 1'b0;
        m_ferr  = 1'b0;
    endtask

    // One clock: drive inputs, check the combinational grant, predict and
    // queue the post-edge state, then pop and compare after the edge.
    task automatic cyc(input logic r, input logic [1:0] iv, input logic [1:0] vr,
                       input logic bc, input logic [4:0] tag);
        logic       full;
        logic [1:0] exp_fire;
        int         exp_id[2];
        int         nxt, nalloc, n, t, j, guard;
        logic       legal, ok, fl;
        exp_t       e;

        @(negedge clk);
        rst               = r;
        instr_val_id      = iv;
        val_ret           = vr;
        branch_clear_id   = bc;
        mispredict_tag_id = tag;
        #1;

        full   = (32 - m_count) < 2;
        nxt    = m_tail;
        nalloc = 0;
        for (int i = 0; i < 2; i++) begin
            exp_fire[i] = !full && !bc && iv[i];
            exp_id[i]   = m_tail;
            if (exp_fire[i]) begin
                exp_id[i] = nxt;
                nxt       = (nxt + 1) % 32;
                nalloc++;
            end
        end
        if (r) begin
            chk("alloc_fire", alloc_fire, exp_fire);
            for (int i = 0; i < 2; i++) begin
                chk(exp_fire[i] ? "alloc_robid" : "alloc_robid_idle", alloc_robid[i], exp_id[i]);
            end
        end

        if (!r) begin
            model_reset();
        end else begin
            t     = tag;
            legal = !(vr[1] && !vr[0]);
            n     = vr[0] + vr[1];
            ok    = legal && (n <= m_count);
            if (!ok) begin
                n      = 0;
                m_rerr = 1'b1;
            end
            fl = bc && m_ety[t];
            if (bc && !m_ety[t]) m_ferr = 1'b1;
            for (int k = 0; k < n; k++) m_ety[(m_head + k) % 32] = 1'b0;
            if (fl) begin
                j     = (t + 1) % 32;
                guard = 0;
                while (j != m_tail && guard < 32) begin
                    m_ety[j] = 1'b0;
                    j        = (j + 1) % 32;
                    guard++;
                end
                m_count = ((t - m_head + 32) % 32) + 1 - n;
                m_tail  = (t + 1) % 32;
            end else begin
                for (int i = 0; i < 2; i++) if (exp_fire[i]) m_ety[exp_id[i]] = 1'b1;
                m_tail  = (m_tail + nalloc) % 32;
                m_count = m_count + nalloc - n;
            end
            m_head = (m_head + n) % 32;
        end

        e.tail  = 5'(m_tail);
        e.head  = 5'(m_head);
        e.count = 6'(m_count);
        e.ety   = m_ety;
        e.full  = (32 - m_count) < 2;
        e.empty = (m_count == 0);
        e.rerr  = m_rerr;
        e.ferr  = m_ferr;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rob_is_ptr",  rob_is_ptr,  e.tail);
        chk("rob_ret_ptr", rob_ret_ptr, e.head);
        chk("rob_count",   rob_count,   e.count);
        chk("rob_ety_val", rob_ety_val, e.ety);
        chk("rob_full",    rob_full,    e.full);
        chk("rob_empty",   rob_empty,   e.empty);
        chk("ret_err",     ret_err,     e.rerr);
        chk("flush_err",   flush_err,   e.ferr);
    endtask

    task automatic do_reset();
        cyc(1'b0, 2'b00, 2'b00, 1'b0, 5'd0);
    endtask

    initial begin
        rst               = 1'b0;
        instr_val_id      = '0;
        val_ret           = '0;
        branch_clear_id   = 1'b0;
        mispredict_tag_id = '0;
        model_reset();

        // Reset state
        do_reset();
        chk("reset_empty", rob_empty, 1);
        chk("reset_full",  rob_full,  0);
        chk("reset_count", rob_count, 0);

        // Fill with dual allocation; 30 used leaves exactly two free
        repeat (15) cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        chk("fill_cnt30",  rob_count,  30);
        chk("fill_tail30", rob_is_ptr, 30);
        chk("fill_full30", rob_full,   0);
        cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        chk("fill_cnt32",  rob_count,  32);
        chk("fill_full32", rob_full,   1);
        repeat (2) cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        chk("fill_tail_hold", rob_is_ptr, 0);

        // Reset in the middle of activity discards everything
        cyc(1'b0, 2'b11, 2'b11, 1'b1, 5'd3);
        chk("midrst_count", rob_count, 0);
        chk("midrst_ety",   rob_ety_val, 0);

        // Retire with nothing in flight
        cyc(1'b1, 2'b00, 2'b01, 1'b0, 5'd0);
        chk("ret_over_err",  ret_err,     1);
        chk("ret_over_head", rob_ret_ptr, 0);

        // Compacted grant with only slot 1 valid
        do_reset();
        repeat (2) cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        cyc(1'b1, 2'b10, 2'b00, 1'b0, 5'd0);
        chk("slot1_tail5", rob_is_ptr, 5);

        // Wrap: drain to head=tail=30 then allocate across the boundary
        do_reset();
        repeat (15) cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        repeat (15) cyc(1'b1, 2'b00, 2'b11, 1'b0, 5'd0);
        chk("wrap_head30", rob_ret_ptr, 30);
        chk("wrap_empty",  rob_empty,   1);
        cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        chk("wrap_ety",   rob_ety_val, 32'hC000_0003);
        chk("wrap_count", rob_count,   4);
        cyc(1'b1, 2'b11, 2'b01, 1'b0, 5'd0);
        chk("wrap_alloc_ret_count", rob_count, 5);

        // Flush: head=2, tail=10, tag=5 with one retire
        do_reset();
        repeat (5) cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        cyc(1'b1, 2'b00, 2'b11, 1'b0, 5'd0);
        chk("pre_flush_count", rob_count, 8);
        cyc(1'b1, 2'b11, 2'b01, 1'b1, 5'd5);
        chk("flush_tail",  rob_is_ptr,  6);
        chk("flush_head",  rob_ret_ptr, 3);
        chk("flush_count", rob_count,   3);
        chk("flush_ety",   rob_ety_val, 32'h0000_0038);
        cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        chk("post_flush_tail", rob_is_ptr, 8);

        // Illegal retire pattern and flush of an id not in flight
        cyc(1'b1, 2'b00, 2'b10, 1'b0, 5'd0);
        chk("ret_err_set",  ret_err,     1);
        chk("ret_err_head", rob_ret_ptr, 3);
        cyc(1'b1, 2'b00, 2'b00, 1'b0, 5'd0);
        chk("ret_err_sticky", ret_err, 1);
        cyc(1'b1, 2'b00, 2'b00, 1'b1, 5'd20);
        chk("flush_err_set",  flush_err,  1);
        chk("flush_err_tail", rob_is_ptr, 8);

        // Nearly full plus retire: full judged on the old count
        do_reset();
        repeat (15) cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        cyc(1'b1, 2'b01, 2'b00, 1'b0, 5'd0);
        chk("cnt31",  rob_count, 31);
        chk("full31", rob_full,  1);
        cyc(1'b1, 2'b11, 2'b11, 1'b0, 5'd0);
        chk("full_ret_count", rob_count,  29);
        chk("full_ret_tail",  rob_is_ptr, 31);
        cyc(1'b1, 2'b11, 2'b00, 1'b0, 5'd0);
        chk("after_full_count", rob_count,  31);
        chk("after_full_tail",  rob_is_ptr, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
